irq_ctrl_8: RTL and testbench
=============================

// Module: irq_ctrl_8
// PURPOSE
//  8-source interrupt controller that sequences the 8-input priority encoder (code 1..8, 0=none).
//  - Synchronises the request lines, holds a pending register and a mask register.
//  - Presents one vector at a time to the CPU over a req/ack handshake, then holds it in service until end-of-interrupt.
//  - Source 0 is highest priority, source 7 lowest.
// PARAMETERS
//  SYNC_STAGES  2      flops per irq input synchroniser; minimum 2
//  MASK_RESET   8'hFF  mask register value after reset (1 = source masked)
// PORTS
//  clk         in   1  system clock, rising-edge
//  reset_n     in   1  asynchronous active-low reset
//  irq         in   8  raw interrupt request lines, async to clk
//  mask_we     in   1  mask write strobe
//  mask_wdata  in   8  new mask value, captured when mask_we=1
//  mask        out  8  current mask register
//  pending     out  8  current pending register (pre-mask)
//  int_req     out  1  interrupt request to CPU
//  int_vec     out  4  vector code 1..8 (source+1); 0 when idle
//  int_ack     in   1  CPU accepts presented vector
//  eoi         in   1  CPU end-of-interrupt pulse
//  busy        out  1  1 while in SERVICE state
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - int_req=0, int_vec=0, busy=0, mask=MASK_RESET, pending=0, sync flops=0, state=IDLE.
//  - Reset mid-handshake abandons the interrupt with no ack or eoi required.
//  Synchroniser: each irq bit passes through SYNC_STAGES flops; irq_s is the last stage.
//  Pending register (level mode): pending = irq_s, so a deasserted line drops out of pending.
//  Mask register:
//  - mask_we=1 loads mask_wdata on the next edge; it affects arbitration from the following cycle.
//  - Mask writes are allowed in any state and never disturb a vector already latched.
//  Arbitration:
//  - active = pending & ~mask.
//  - code = 1-based index of the lowest set bit of active; 0 if none.
//  FSM (IDLE, REQ, SERVICE):
//  - IDLE: int_req=0, int_vec=0. code!=0 -> REQ; int_vec<=code and int_req<=1 on that edge.
//  - REQ: int_req and int_vec are held stable and locked.
//      - Source withdrawal, masking, or a higher-priority arrival does NOT retract or change the vector.
//      - int_ack=1 -> SERVICE; int_req<=0 on that edge, busy<=1, int_vec held.
//  - SERVICE: int_vec held, busy=1, no new request raised. eoi=1 -> IDLE; busy<=0, int_vec<=0.
//  - Re-arbitration: one full IDLE cycle always separates SERVICE from the next REQ.
//  Ignored inputs:
//  - int_ack outside REQ is ignored; eoi outside SERVICE is ignored.
//  - Simultaneous int_ack and eoi in REQ: treated as ack only.
//  Latency: irq high first sampled at edge 1 -> int_req=1 after edge SYNC_STAGES+1 (3 by default).
// CONFIGURATION
//  IRQ_CTRL_EDGE_EN undefined: level-sensitive pending, as above.
//  IRQ_CTRL_EDGE_EN defined: rising-edge latched pending.
//  - A rising edge on irq_s (vs a one-cycle-delayed copy) sets pending[i] sticky.
//  - pending[i] clears on the int_ack edge for the acked source.
//  - A new edge on that same source in the ack cycle keeps it set.
//  - Masked sources still latch edges and are serviced once unmasked.
//  - Latency becomes SYNC_STAGES+2 edges.
// TESTING
//  1. Reset: reset_n=0 mid-REQ -> int_req=0, int_vec=0, busy=0, mask=8'hFF immediately (async).
//  2. mask=0, irq=8'b1010_0000:
//     - int_req=1 and int_vec=4'd6 three edges after irq set.
//     - ack -> busy=1; eoi -> IDLE; next REQ int_vec=4'd8 (level mode, irq still high).
//  3. Lock: in REQ with int_vec=4'd5, raise irq[0] -> int_vec stays 5.
//     - After ack+eoi, next int_vec=4'd1.
//  4. Mask: mask=8'hFE, irq=8'h01 -> int_req stays 0.
//     - Write mask=8'h00 -> int_req=1, int_vec=4'd1 within 2 cycles.
//  5. Ignored strobes: eoi in IDLE, int_ack in SERVICE -> no state change.
//     - Simultaneous int_ack+eoi in REQ -> SERVICE.
//  6. IRQ_CTRL_EDGE_EN: 1-cycle pulse on irq[3] -> pending[3] sticky, int_vec=4'd4 at SYNC_STAGES+2.
//     - Pending clears on ack; a second pulse during SERVICE is serviced after eoi.

Source files
------------

// File: rtl/irq_ctrl_8.sv
// 8-source interrupt controller: synchronised requests, mask, fixed priority (source 0 highest),
// req/ack/eoi handshake to the CPU. Define IRQ_CTRL_EDGE_EN for rising-edge latched pending.
module irq_ctrl_8 #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MASK_RESET  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    output logic [7:0] mask,
    output logic [7:0] pending,
    output logic       int_req,
    output logic [3:0] int_vec,
    input  logic       int_ack,
    input  logic       eoi,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest set bit wins; result is the 1-based source index, 0 when nothing is active.
    function automatic logic [3:0] prio_code(input logic [7:0] act);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            c = act[i] ? 4'(i + 1) : c;
        end
        return c;
    endfunction

    // One-hot source select for a 1-based vector code; all zero for code 0.
    function automatic logic [7:0] vec_to_bit(input logic [3:0] v);
        logic [7:0] b;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            b[i] = (v == 4'(i + 1));
        end
        return b;
    endfunction

    logic [7:0] sync_r [SYNC_STAGES];
    logic [7:0] irq_s;
    logic [7:0] mask_r;
    logic [7:0] pend_s;
    logic [7:0] active_s;
    logic [3:0] code_s;
    state_t     state_r;
    state_t     state_nxt_s;
    logic       int_req_r;
    logic       req_nxt_s;
    logic [3:0] int_vec_r;
    logic [3:0] vec_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;

    // Request synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 8'd0;
            end
        end else begin
            sync_r[0] <= irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign irq_s = sync_r[SYNC_STAGES-1];

`ifdef IRQ_CTRL_EDGE_EN
    logic [7:0] irq_d_r;
    logic [7:0] pending_r;
    logic [7:0] rise_s;
    logic [7:0] clr_s;

    assign rise_s = irq_s & ~irq_d_r;

    // Only the acked source is cleared; an edge arriving in that same cycle re-sets it.
    always_comb begin
        clr_s = 8'd0;
        if ((state_r == ST_REQ) && int_ack) begin
            clr_s = vec_to_bit(int_vec_r);
        end else begin
            clr_s = 8'd0;
        end
    end

    // Edge detector history and sticky pending bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_d_r   <= 8'd0;
            pending_r <= 8'd0;
        end else begin
            irq_d_r   <= irq_s;
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    assign pend_s = pending_r;
`else
    assign pend_s = irq_s;
`endif

    // Mask register; new value takes part in arbitration from the cycle after the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= MASK_RESET;
        end else if (mask_we) begin
            mask_r <= mask_wdata;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign active_s = pend_s & ~mask_r;
    assign code_s   = prio_code(active_s);

    // Next-state and next-output logic; the vector is frozen from REQ until eoi.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = int_req_r;
        vec_nxt_s   = int_vec_r;
        busy_nxt_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (code_s != 4'd0) begin
                    state_nxt_s = ST_REQ;
                    req_nxt_s   = 1'b1;
                    vec_nxt_s   = code_s;
                    busy_nxt_s  = 1'b0;
                end else begin
                    req_nxt_s   = 1'b0;
                    vec_nxt_s   = 4'd0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_nxt_s = ST_SERVICE;
                    req_nxt_s   = 1'b0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    req_nxt_s   = 1'b1;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                    vec_nxt_s   = 4'd0;
                    busy_nxt_s  = 1'b0;
                end else begin
                    req_nxt_s   = 1'b0;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
                vec_nxt_s   = 4'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered CPU-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            int_req_r <= 1'b0;
            int_vec_r <= 4'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            int_req_r <= req_nxt_s;
            int_vec_r <= vec_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign mask    = mask_r;
    assign pending = pend_s;
    assign int_req = int_req_r;
    assign int_vec = int_vec_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Directed bench for irq_ctrl_8: table of per-cycle vectors plus hand sequences for
// async reset, request latency and (with IRQ_CTRL_EDGE_EN) sticky edge pending.
module tb_irq_ctrl_8;

`ifdef IRQ_CTRL_EDGE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       int_req;
    logic [3:0] int_vec;
    logic       int_ack;
    logic       eoi;
    logic       busy;

    int n_applied;
    int n_miscompares;

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic       eoi;
        logic       e_req;
        logic [3:0] e_vec;
        logic       e_busy;
        logic [7:0] e_mask;
        logic [7:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    irq_ctrl_8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] i, input logic we, input logic [7:0] wd,
                                input logic a, input logic e, input logic rq,
                                input logic [3:0] v, input logic b, input logic [7:0] m,
                                input logic [7:0] p);
        vec_t t;
        t.irq = i; t.we = we; t.wd = wd; t.ack = a; t.eoi = e;
        t.e_req = rq; t.e_vec = v; t.e_busy = b; t.e_mask = m; t.e_pend = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for int_req with a cycle budget; returns edges seen (99 if it never rose).
    task automatic wait_req(output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (int_req) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        n_applied = 0;
        n_miscompares = 0;
        reset_n = 1'b0; irq = 8'd0; mask_we = 1'b0; mask_wdata = 8'd0;
        int_ack = 1'b0; eoi = 1'b0;

        // Level-mode cycle table: irq, we, wdata, ack, eoi | req, vec, busy, mask, pending.
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'hA0));
        tbl.push_back(mk(8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 8'h00, 8'hA0));
        tbl.push_back(mk(8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 8'h00, 8'hA0));
        tbl.push_back(mk(8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h80));
        tbl.push_back(mk(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 8'h00, 8'h80));
        tbl.push_back(mk(8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 8'h80));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 8'h80));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h01, 8'h00));
        tbl.push_back(mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h01, 8'h01));
        tbl.push_back(mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h01, 8'h01));
        tbl.push_back(mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h01, 8'h01));
        tbl.push_back(mk(8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h01));
        tbl.push_back(mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 8'h01));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 8'h00, 8'h01));
        tbl.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h10));
        tbl.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00, 8'h10));
        tbl.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00, 8'h10));
        tbl.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(8'h11, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'hFF, 8'h11));
        tbl.push_back(mk(8'h11, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 8'h00, 8'h11));
        tbl.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'h00, 8'h00));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(int_req), 32'd0);
        chk("rst.vec", 32'(int_vec), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mask", 32'(mask), 32'hFF);
        chk("rst.pend", 32'(pending), 32'h00);
        reset_n = 1'b1;
        step();

        // Request latency, then async reset in the middle of REQ
        mask_we = 1'b1; mask_wdata = 8'h00;
        step();
        mask_we = 1'b0;
        irq = 8'h04;
        wait_req(n);
        chk("lat.edges", 32'(n), 32'(LAT));
        chk("lat.vec", 32'(int_vec), 32'd3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst.req", 32'(int_req), 32'd0);
        chk("arst.vec", 32'(int_vec), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.mask", 32'(mask), 32'hFF);
        irq = 8'h00;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

`ifdef IRQ_CTRL_EDGE_EN
        mask_we = 1'b1; mask_wdata = 8'h00;
        step();
        mask_we = 1'b0;
        irq = 8'h08;
        step();
        irq = 8'h00;
        wait_req(n);
        chk("edge.lat", 32'(n + 1), 32'(LAT));
        chk("edge.vec", 32'(int_vec), 32'd4);
        chk("edge.sticky", 32'(pending), 32'h08);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("edge.ack_busy", 32'(busy), 32'd1);
        chk("edge.ack_clr", 32'(pending), 32'h00);
        irq = 8'h08;
        step();
        irq = 8'h00;
        repeat (4) step();
        chk("edge.svc_pend", 32'(pending), 32'h08);
        chk("edge.svc_req", 32'(int_req), 32'd0);
        chk("edge.svc_vec", 32'(int_vec), 32'd4);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("edge.eoi_busy", 32'(busy), 32'd0);
        chk("edge.eoi_vec", 32'(int_vec), 32'd0);
        wait_req(n);
        chk("edge.rearb", 32'(n), 32'd1);
        chk("edge.vec2", 32'(int_vec), 32'd4);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
`else
        foreach (tbl[i]) begin
            irq = tbl[i].irq; mask_we = tbl[i].we; mask_wdata = tbl[i].wd;
            int_ack = tbl[i].ack; eoi = tbl[i].eoi;
            step();
            chk($sformatf("v%0d.req", i), 32'(int_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d.vec", i), 32'(int_vec), 32'(tbl[i].e_vec));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d.mask", i), 32'(mask), 32'(tbl[i].e_mask));
            chk($sformatf("v%0d.pend", i), 32'(pending), 32'(tbl[i].e_pend));
        end
        irq = 8'h00; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
